genaxis_descriptor_to_axis_mc: RTL and testbench

Next-generation descriptor-driven AXI-Stream packet generator for the axis_generator traffic source. It consumes one descriptor per burst and emits repeat+1 identical-length packets on one AXIS master, with a programmable inter-packet pause. Payload comes from one of three data modes: PRBS input, incrementing byte counter, or constant fill. It replaces the single-shot PRBS-only generator and adds full AXIS-compliant backpressure and a status pulse.

---
 rtl/genaxis_descriptor_to_axis_mc.sv | 201 ++++++++++++++++++++
 tb/tb_genaxis_descriptor_to_axis_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/genaxis_descriptor_to_axis_mc.sv
// Descriptor-driven AXI-Stream packet generator: one descriptor yields repeat+1
// equal-length packets with an optional inter-packet pause and PRBS/INC/FILL payload.
module genaxis_descriptor_to_axis_mc #(
    parameter int ID_WIDTH     = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int TKEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LEN_WIDTH    = 16,
    parameter int PAUSE_WIDTH  = 32,
    parameter int REPEAT_WIDTH = 8,
    parameter int DESC_WIDTH   = 2 + REPEAT_WIDTH + ID_WIDTH + PAUSE_WIDTH + LEN_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH-1:0]  psrand_data_i,
    input  logic [7:0]             fill_byte_i,
    input  logic [DESC_WIDTH-1:0]  in_descriptor_data_i,
    input  logic                   in_descriptor_valid_i,
    output logic                   in_descriptor_ready_o,
    output logic [ID_WIDTH-1:0]    m_axis_tid_o,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata_o,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep_o,
    output logic                   m_axis_tlast_o,
    output logic                   m_axis_tvalid_o,
    input  logic                   m_axis_tready_i,
    output logic                   busy_o,
    output logic                   pkt_done_o
);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_PAUSE} state_t;

    localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(TKEEP_WIDTH);
    localparam logic [7:0]           BYTES_B = 8'(TKEEP_WIDTH);

    state_t                  r_state, w_state_nxt;
    logic [1:0]              r_mode;
    logic [REPEAT_WIDTH-1:0] r_rep_cnt;
    logic [ID_WIDTH-1:0]     r_chan;
    logic [PAUSE_WIDTH-1:0]  r_pause, r_pause_cnt;
    logic [LEN_WIDTH-1:0]    r_len, r_rem_len;
    logic [7:0]              r_byte_idx, r_fill;
    logic                    r_tvalid, r_tlast, r_busy, r_pkt_done;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [TKEEP_WIDTH-1:0]  r_tkeep;
    logic [ID_WIDTH-1:0]     r_tid;

    logic [LEN_WIDTH-1:0]    w_d_len;
    logic [PAUSE_WIDTH-1:0]  w_d_pause;
    logic [ID_WIDTH-1:0]     w_d_chan;
    logic [REPEAT_WIDTH-1:0] w_d_rep;
    logic [1:0]              w_d_mode;

    assign w_d_len   = in_descriptor_data_i[LEN_WIDTH-1:0];
    assign w_d_pause = in_descriptor_data_i[LEN_WIDTH +: PAUSE_WIDTH];
    assign w_d_chan  = in_descriptor_data_i[LEN_WIDTH+PAUSE_WIDTH +: ID_WIDTH];
    assign w_d_rep   = in_descriptor_data_i[LEN_WIDTH+PAUSE_WIDTH+ID_WIDTH +: REPEAT_WIDTH];
    assign w_d_mode  = in_descriptor_data_i[DESC_WIDTH-1 -: 2];

    logic w_hs, w_can_load, w_pkt_end;
    logic w_start, w_reload, w_enter_pause, w_load;
    logic [LEN_WIDTH-1:0]   w_cur_rem, w_rem_nxt;
    logic [7:0]             w_cur_idx, w_idx_nxt;
    logic                   w_beat_last;
    logic [TKEEP_WIDTH-1:0] w_beat_keep;
    logic [DATA_WIDTH-1:0]  w_beat_data;

    assign w_hs       = r_tvalid & m_axis_tready_i;
    assign w_can_load = ~r_tvalid | m_axis_tready_i;
    // A zero-length packet (or its remainder) ends with no beat in flight.
    assign w_pkt_end  = (w_hs & r_tlast) | ((r_rem_len == '0) & ~r_tvalid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_start       = 1'b0;
        w_reload      = 1'b0;
        w_enter_pause = 1'b0;
        w_load        = 1'b0;
        w_cur_rem     = r_rem_len;
        w_cur_idx     = r_byte_idx;
        case (r_state)
            S_IDLE: begin
                if (in_descriptor_valid_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (w_pkt_end) begin
                    if (r_pause != '0) begin
                        w_enter_pause = 1'b1;
                        w_state_nxt   = S_PAUSE;
                    end else if (r_rep_cnt != '0) begin
                        w_reload = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                // On a back-to-back repeat the next packet's first beat loads this cycle.
                if (w_reload) begin
                    w_cur_rem = r_len;
                    w_cur_idx = '0;
                end
                w_load = (w_state_nxt == S_XFER) & w_can_load & (w_cur_rem != '0);
            end
            S_PAUSE: begin
                if (r_pause_cnt <= PAUSE_WIDTH'(1)) begin
                    if (r_rep_cnt != '0) begin
                        w_reload    = 1'b1;
                        w_state_nxt = S_XFER;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_beat_last = (w_cur_rem <= BYTES_L);
        w_rem_nxt   = w_beat_last ? '0 : (w_cur_rem - BYTES_L);
        w_idx_nxt   = w_cur_idx + BYTES_B;
        w_beat_keep = '0;
        w_beat_data = '0;
        for (int i = 0; i < TKEEP_WIDTH; i++) begin
            w_beat_keep[i] = (LEN_WIDTH'(i) < w_cur_rem);
            case (r_mode)
                2'd1:    w_beat_data[8*i +: 8] = w_cur_idx + 8'(i);
                2'd2:    w_beat_data[8*i +: 8] = r_fill;
                default: w_beat_data[8*i +: 8] = psrand_data_i[8*i +: 8];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode      <= '0;
            r_rep_cnt   <= '0;
            r_chan      <= '0;
            r_pause     <= '0;
            r_pause_cnt <= '0;
            r_len       <= '0;
            r_rem_len   <= '0;
            r_byte_idx  <= '0;
            r_fill      <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tid       <= '0;
            r_busy      <= 1'b0;
            r_pkt_done  <= 1'b0;
        end else begin
            if (w_start) begin
                r_mode     <= w_d_mode;
                r_rep_cnt  <= w_d_rep;
                r_chan     <= w_d_chan;
                r_pause    <= w_d_pause;
                r_len      <= w_d_len;
                r_rem_len  <= w_d_len;
                r_byte_idx <= '0;
                r_fill     <= fill_byte_i;
            end
            if (w_reload) begin
                r_rep_cnt  <= r_rep_cnt - 1'b1;
                r_rem_len  <= r_len;
                r_byte_idx <= '0;
            end
            if (w_enter_pause)          r_pause_cnt <= r_pause;
            else if (r_state == S_PAUSE) r_pause_cnt <= r_pause_cnt - 1'b1;
            if (w_load) begin
                r_rem_len  <= w_rem_nxt;
                r_byte_idx <= w_idx_nxt;
                r_tvalid   <= 1'b1;
                r_tlast    <= w_beat_last;
                r_tkeep    <= w_beat_keep;
                r_tdata    <= w_beat_data;
                r_tid      <= r_chan;
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
            r_pkt_done <= w_hs & r_tlast;
            r_busy     <= (w_state_nxt != S_IDLE);
        end
    end

    assign in_descriptor_ready_o = (r_state == S_IDLE);
    assign m_axis_tid_o          = r_tid;
    assign m_axis_tdata_o        = r_tdata;
    assign m_axis_tkeep_o        = r_tkeep;
    assign m_axis_tlast_o        = r_tlast;
    assign m_axis_tvalid_o       = r_tvalid;
    assign busy_o                = r_busy;
    assign pkt_done_o            = r_pkt_done;

endmodule

// File: tb/tb_genaxis_descriptor_to_axis_mc.sv
// Randomized bench for genaxis_descriptor_to_axis_mc: a beat-list model built from the
// descriptor rules is compared against the AXIS output on every cycle.
module tb_genaxis_descriptor_to_axis_mc;
    localparam int DW = 32, BY = 4, IDW = 10, LW = 16, PW = 32, RW = 8;
    localparam int DESCW = 2 + RW + IDW + PW + LW;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [DW-1:0] psrand = '0;
    logic [7:0] fill = '0;
    logic [DESCW-1:0] desc = '0;
    logic dvalid = 1'b0, dready;
    logic [IDW-1:0] tid;
    logic [DW-1:0] tdata;
    logic [BY-1:0] tkeep;
    logic tlast, tvalid, tready = 1'b1, busy, pkt_done;

    genaxis_descriptor_to_axis_mc dut (
        .clk(clk), .reset_n(reset_n), .psrand_data_i(psrand), .fill_byte_i(fill),
        .in_descriptor_data_i(desc), .in_descriptor_valid_i(dvalid), .in_descriptor_ready_o(dready),
        .m_axis_tid_o(tid), .m_axis_tdata_o(tdata), .m_axis_tkeep_o(tkeep),
        .m_axis_tlast_o(tlast), .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
        .busy_o(busy), .pkt_done_o(pkt_done));

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]  data;
        logic [BY-1:0]  keep;
        logic           last;
        logic [IDW-1:0] tid;
        logic           prbs;
    } beat_t;

    beat_t exp_q[$];
    beat_t cap_q[$];
    int nvec = 0, nerr = 0;
    int tr_mode = 0, cyc = 0;
    int n_hs = 0, n_done = 0, n_tv = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sink readiness and PRBS source change just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        psrand = $urandom;
        case (tr_mode)
            0:       tready = 1'b1;
            1:       tready = (cyc % 3 == 0);
            default: tready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Reference beats for one descriptor, straight from the length/mode rules.
    task automatic push_exp(input int mode, input int rep, input int chan, input int len, input int fb);
        int nb;
        beat_t b;
        nb = (len + BY - 1) / BY;
        for (int p = 0; p <= rep; p++)
            for (int k = 0; k < nb; k++) begin
                int rem;
                rem = len - k * BY;
                b.last = (rem <= BY);
                b.tid  = IDW'(chan);
                b.prbs = (mode == 0 || mode == 3);
                for (int i = 0; i < BY; i++) begin
                    b.keep[i] = (i < rem);
                    if (mode == 1)      b.data[8*i +: 8] = 8'((k * BY + i) % 256);
                    else if (mode == 2) b.data[8*i +: 8] = 8'(fb);
                    else                b.data[8*i +: 8] = 8'h00;
                end
                exp_q.push_back(b);
            end
    endtask

    // Cycles spent outside IDLE with an always-ready sink.
    function automatic int exp_busy(input int rep, input int pause, input int len);
        int nb;
        nb = (len + BY - 1) / BY;
        if (nb == 0) return (rep + 1) * (1 + pause);
        return 1 + (rep + 1) * (nb + pause) + rep * ((pause != 0) ? 1 : 0);
    endfunction

    initial begin
        beat_t e;
        logic [DW-1:0] m;
        logic p_tv = 1'b0, p_tr = 1'b0, p_tl = 1'b0;
        logic [DW-1:0] p_data = '0, p_psr = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                p_tv = 1'b0; p_tr = 1'b0; p_tl = 1'b0;
            end else begin
                chk("ready_vs_busy", dready, !busy);
                chk("pkt_done", pkt_done, p_tv & p_tr & p_tl);
                if (pkt_done) n_done++;
                if (tvalid) begin
                    n_tv++;
                    chk("beat_expected", 64'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        for (int i = 0; i < BY; i++) m[8*i +: 8] = {8{e.keep[i]}};
                        chk("tkeep", tkeep, e.keep);
                        chk("tlast", tlast, e.last);
                        chk("tid", tid, e.tid);
                        if (p_tv && !p_tr) chk("stall_data", tdata & m, p_data & m);
                        else if (e.prbs)   chk("prbs_data", tdata & m, p_psr & m);
                        if (!e.prbs)       chk("data", tdata & m, e.data & m);
                        if (tready) begin
                            void'(exp_q.pop_front());
                            cap_q.push_back('{tdata, tkeep, tlast, tid, 1'b0});
                            n_hs++;
                        end
                    end
                end
                p_tv = tvalid; p_tr = tready; p_tl = tlast;
                p_data = tdata; p_psr = psrand;
            end
        end
    end

    task automatic accept(input int mode, input int rep, input int chan, input int pause,
                          input int len, input int fb);
        int t;
        t = 0;
        @(negedge clk);
        while (!dready && t < 1000) begin @(negedge clk); t++; end
        chk("ready_wait", 64'(t < 1000), 1);
        push_exp(mode, rep, chan, len, fb);
        n_hs = 0; n_done = 0; n_tv = 0;
        cap_q.delete();
        desc = {2'(mode), RW'(rep), IDW'(chan), PW'(pause), LW'(len)};
        fill = 8'(fb);
        dvalid = 1'b1;
        @(posedge clk);
        #1;
        dvalid = 1'b0;
        fill = 8'($urandom);
        desc = DESCW'($urandom);
    endtask

    task automatic run_desc(input int mode, input int rep, input int chan, input int pause,
                            input int len, input int fb);
        int bc, t;
        accept(mode, rep, chan, pause, len, fb);
        @(negedge clk);
        chk("lat1_tvalid", tvalid, 0);
        bc = 0; t = 0;
        while (busy && t < 5000) begin
            bc++;
            if (bc == 2) chk("lat2_tvalid", tvalid, 64'(len != 0));
            @(negedge clk);
            t++;
        end
        #1;
        chk("burst_timeout", 64'(t < 5000), 1);
        chk("ready_after", dready, 1);
        chk("queue_drained", 64'(exp_q.size()), 0);
        if (tr_mode == 0) chk("busy_cycles", 64'(bc), 64'(exp_busy(rep, pause, len)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tvalid", tvalid, 0); chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);   chk("rst_tkeep", tkeep, 0);
        chk("rst_tid", tid, 0);       chk("rst_busy", busy, 0);
        chk("rst_done", pkt_done, 0); chk("rst_ready", dready, 1);
        #2 reset_n = 1'b1;

        // INC, 10 bytes
        tr_mode = 0;
        run_desc(1, 0, 10'h155, 0, 10, 0);
        chk("t1_nbeats", 64'(cap_q.size()), 3);
        if (cap_q.size() == 3) begin
            chk("t1_d0", cap_q[0].data, 32'h03020100);
            chk("t1_d1", cap_q[1].data, 32'h07060504);
            chk("t1_d2", cap_q[2].data[15:0], 16'h0908);
            chk("t1_k", {cap_q[0].keep, cap_q[1].keep, cap_q[2].keep}, 12'hFF3);
            chk("t1_l", {cap_q[0].last, cap_q[1].last, cap_q[2].last}, 3'b001);
        end
        chk("t1_done", 64'(n_done), 1);

        // FILL with repeats and pause
        run_desc(2, 2, 7, 3, 8, 8'hA5);
        chk("t2_done", 64'(n_done), 3);
        chk("t2_tv", 64'(n_tv), 6);
        if (cap_q.size() > 0) chk("t2_fill", cap_q[0].data, 32'hA5A5A5A5);

        // PRBS with stalling sink
        tr_mode = 1;
        run_desc(0, 0, 3, 0, 16, 0);
        chk("t3_hs", 64'(n_hs), 4);
        chk("t3_done", 64'(n_done), 1);

        // single-beat back-to-back packets
        tr_mode = 0;
        run_desc(1, 1, 1, 0, 4, 0);
        chk("t4_tv", 64'(n_tv), 2);
        chk("t4_done", 64'(n_done), 2);

        // zero length with pause
        run_desc(1, 0, 2, 5, 0, 0);
        chk("t5_tv", 64'(n_tv), 0);
        chk("t5_done", 64'(n_done), 0);

        // reset during beat 2 of a 5-beat packet
        accept(1, 0, 9, 0, 20, 0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mr_tvalid", tvalid, 0); chk("mr_tlast", tlast, 0);
        chk("mr_tdata", tdata, 0);   chk("mr_tkeep", tkeep, 0);
        chk("mr_tid", tid, 0);       chk("mr_busy", busy, 0);
        chk("mr_done", pkt_done, 0); chk("mr_ready", dready, 1);
        exp_q.delete();
        @(negedge clk);
        #2 reset_n = 1'b1;
        run_desc(1, 0, 9, 0, 20, 0);
        chk("mr_clean_hs", 64'(n_hs), 5);

        for (int k = 0; k < 16; k++) begin
            tr_mode = $urandom_range(0, 2);
            run_desc($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1023),
                     $urandom_range(0, 3), $urandom_range(0, 25), $urandom_range(0, 255));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
